// File: rtl/fetch_pkg.sv
// Shared fetch types: boot address, queue entry layout, FSM states and the
// instruction-side exception cause codes consumed by decode.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [3:0] ERR_IALIGN   = 4'd0;
  localparam logic [3:0] ERR_IFAULT   = 4'd1;
  localparam logic [3:0] ERR_IILLEGAL = 4'd2;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [31:1] addr;
    logic [15:0] bptag;
    logic        bptaken;
    logic        filled;
    logic        error;
    logic [31:0] insn;
  } fq_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus bundle: redirect, icache request/response, predictor lookup
// and the decode handoff. master = fetch, slave = its environment.
interface fetch_if;
  logic        rob_flush;
  logic [31:1] rob_flush_pc;
  logic        icache_req_valid;
  logic [31:2] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic        icache_resp_error;
  logic [31:0] icache_resp_data;
  logic [31:2] bp_addr;
  logic        bp_taken;
  logic [15:0] bp_tag;
  logic [31:2] bp_target;
  logic        fetch_de_valid;
  logic        fetch_de_error;
  logic [31:1] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic [15:0] fetch_de_bptag;
  logic        fetch_de_bptaken;
  logic        decode_stall;

  modport master (
    input  rob_flush, rob_flush_pc, icache_req_ready,
           icache_resp_valid, icache_resp_error, icache_resp_data,
           bp_taken, bp_tag, bp_target, decode_stall,
    output icache_req_valid, icache_req_addr, bp_addr,
           fetch_de_valid, fetch_de_error, fetch_de_addr, fetch_de_insn,
           fetch_de_bptag, fetch_de_bptaken
  );

  modport slave (
    output rob_flush, rob_flush_pc, icache_req_ready,
           icache_resp_valid, icache_resp_error, icache_resp_data,
           bp_taken, bp_tag, bp_target, decode_stall,
    input  icache_req_valid, icache_req_addr, bp_addr,
           fetch_de_valid, fetch_de_error, fetch_de_addr, fetch_de_insn,
           fetch_de_bptag, fetch_de_bptaken
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer: allocate at tail, fill the oldest unfilled slot,
// pop at head. Flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alloc,
  input  fq_entry_t     alloc_ent,
  input  logic          fill,
  input  logic          fill_err,
  input  logic [31:0]   fill_data,
  input  logic          pop,
  output logic          full,
  output logic          head_occ,
  output fq_entry_t     head,
  output logic [CW-1:0] unfilled
);
  fq_entry_t       ent [QDEPTH];
  logic [PW-1:0]   hd, tl, fill_idx;
  logic [CW-1:0]   cnt;
  logic            fill_hit, do_alloc, do_pop;

  assign full     = (cnt == CW'(QDEPTH));
  assign head_occ = (cnt != '0);
  assign head     = ent[hd];
  assign do_alloc = alloc && !full;
  assign do_pop   = pop && head_occ && ent[hd].filled;

  // Oldest unfilled slot is the target of the next in-order response.
  always_comb begin
    logic [PW-1:0] idx;
    unfilled = '0;
    fill_idx = hd;
    fill_hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = hd + PW'(i);
      if (CW'(i) < cnt && !ent[idx].filled) begin
        unfilled = unfilled + CW'(1);
        if (!fill_hit) begin
          fill_hit = 1'b1;
          fill_idx = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      if (do_alloc) begin
        ent[tl] <= alloc_ent;
        tl      <= tl + 1'b1;
      end
      if (fill && fill_hit) begin
        ent[fill_idx].filled <= 1'b1;
        ent[fill_idx].error  <= fill_err;
        ent[fill_idx].insn   <= fill_data;
      end
      if (do_pop) hd <= hd + 1'b1;
      cnt <= cnt + CW'(do_alloc) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch.sv
// Instruction fetch: pc/predictor steering, RUN/HALT control, and discard of
// responses that belong to requests issued before a redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e  state, state_nx;
  logic [31:1]   pc, pc_nx;
  logic [CW-1:0] drop, drop_nx, unfilled;
  logic          full, head_occ, req_beat, bad_align, fill, pop;
  fq_entry_t     head, alloc_ent;

  assign bus.icache_req_addr  = pc[31:2];
  assign bus.bp_addr          = pc[31:2];
  assign bus.icache_req_valid = rst_n && state == RUN && !full && !pc[1] && !bus.rob_flush;
  assign req_beat  = bus.icache_req_valid && bus.icache_req_ready;
  assign bad_align = state == RUN && pc[1] && !full && !bus.rob_flush;
  assign fill      = bus.icache_resp_valid && drop == '0;
  assign pop       = bus.fetch_de_valid && !bus.decode_stall;

  assign bus.fetch_de_valid   = head_occ && head.filled;
  assign bus.fetch_de_error   = head.error;
  assign bus.fetch_de_addr    = head.addr;
  assign bus.fetch_de_insn    = head.insn;
  assign bus.fetch_de_bptag   = head.bptag;
  assign bus.fetch_de_bptaken = head.bptaken;

  // A misaligned pc becomes a pre-filled fault entry instead of a request.
  always_comb begin
    alloc_ent      = '0;
    alloc_ent.addr = pc;
    if (bad_align) begin
      alloc_ent.filled = 1'b1;
      alloc_ent.error  = 1'b1;
    end else begin
      alloc_ent.bptag   = bus.bp_tag;
      alloc_ent.bptaken = bus.bp_taken;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_fq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.rob_flush),
    .alloc     (req_beat || bad_align),
    .alloc_ent (alloc_ent),
    .fill      (fill),
    .fill_err  (bus.icache_resp_error),
    .fill_data (bus.icache_resp_data),
    .pop       (pop),
    .full      (full),
    .head_occ  (head_occ),
    .head      (head),
    .unfilled  (unfilled)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    drop_nx  = drop;
    if (bus.rob_flush) begin
      // Every in-flight request, old drops included, must be swallowed;
      // a response landing this cycle already accounts for one of them.
      state_nx = RUN;
      pc_nx    = bus.rob_flush_pc;
      drop_nx  = drop + unfilled + CW'(req_beat) - CW'(bus.icache_resp_valid);
    end else begin
      if (req_beat)
        pc_nx = bus.bp_taken ? {bus.bp_target, 1'b0} : pc + 31'd2;
      if (bad_align || (fill && bus.icache_resp_error))
        state_nx = HALT;
      if (bus.icache_resp_valid && drop != '0)
        drop_nx = drop - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC[31:1];
      drop  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      drop  <= drop_nx;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// Directed fetch bench: icache/predictor models drive the DUT, expected decode
// entries are queued by the stimulus and checked by an independent monitor.
module tb_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch #(.RESET_PC(32'h0), .QDEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] insn;
    logic        err;
    logic        bpt;
    logic [15:0] tag;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend[$];
  int    de_wins[$];
  int    n_chk = 0, n_fail = 0;
  int    win = -1, nbeat = 0, nresp = 0, lat = 1, err_idx = -1;
  logic  bp_en = 1'b0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Predictor: only pc 0x8 predicts taken, to 0x100.
  always_comb begin
    bus.bp_taken  = bp_en && (bus.bp_addr == 30'h2);
    bus.bp_tag    = bus.bp_taken ? 16'hBEEF : 16'h0000;
    bus.bp_target = 30'h40;
  end

  // Icache: in-order responses 'lat' windows after each request beat.
  always begin : icache
    pend_t p;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      pend.delete();
      win = -1; nbeat = 0; nresp = 0;
      bus.icache_resp_valid = 1'b0;
      bus.icache_resp_error = 1'b0;
      bus.icache_resp_data  = '0;
    end else begin
      win++;
      bus.icache_resp_valid = 1'b0;
      bus.icache_resp_error = 1'b0;
      bus.icache_resp_data  = '0;
      if (pend.size() > 0 && pend[0].due <= win) begin
        p = pend.pop_front();
        bus.icache_resp_valid = 1'b1;
        bus.icache_resp_data  = f(p.addr);
        bus.icache_resp_error = (nresp == err_idx);
        nresp++;
      end
      if (bus.icache_req_valid && bus.icache_req_ready) begin
        pend.push_back('{{bus.icache_req_addr, 2'b00}, win + lat});
        nbeat++;
      end
    end
  end

  always begin : monitor
    exp_t e;
    @(negedge clk);
    #3;
    if (rst_n && bus.fetch_de_valid && !bus.decode_stall) begin
      de_wins.push_back(win);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_entry: got addr %h insn %h, none expected",
                 {bus.fetch_de_addr, 1'b0}, bus.fetch_de_insn);
      end else begin
        e = exp_q.pop_front();
        chk("de_addr",    {bus.fetch_de_addr, 1'b0},     e.addr);
        chk("de_insn",    bus.fetch_de_insn,             e.insn);
        chk("de_error",   32'(bus.fetch_de_error),       32'(e.err));
        chk("de_bptaken", 32'(bus.fetch_de_bptaken),     32'(e.bpt));
        chk("de_bptag",   32'(bus.fetch_de_bptag),       32'(e.tag));
      end
    end
  end

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] insn, input logic err,
                      input logic bpt, input logic [15:0] tag);
    exp_q.push_back('{a, insn, err, bpt, tag});
  endtask

  // Asserts reset mid-cycle, checks cleared outputs, releases at a negedge
  // so the caller is positioned at the start of window 0.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_de_valid", 32'(bus.fetch_de_valid),   32'd0);
    chk("rst_req_valid", 32'(bus.icache_req_valid), 32'd0);
    chk("rst_de_addr",  32'(bus.fetch_de_addr),    32'd0);
    chk("rst_de_insn",  bus.fetch_de_insn,         32'd0);
    chk("rst_de_misc",  32'({bus.fetch_de_error, bus.fetch_de_bptaken, bus.fetch_de_bptag}), 32'd0);
    nxt(2);
    exp_q.delete();
    de_wins.delete();
    bus.rob_flush        = 1'b0;
    bus.rob_flush_pc     = '0;
    bus.icache_req_ready = 1'b0;
    bus.decode_stall     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic end_test(input string nm);
    nxt(8);
    chk({nm, "_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.rob_flush = 1'b0; bus.rob_flush_pc = '0;
    bus.icache_req_ready = 1'b0; bus.decode_stall = 1'b0;

    // Straight-line fetch from reset, minimum latency.
    do_reset();
    bus.icache_req_ready = 1'b1;
    push(32'h0, f(32'h0), 1'b0, 1'b0, 16'h0);
    push(32'h4, f(32'h4), 1'b0, 1'b0, 16'h0);
    push(32'h8, f(32'h8), 1'b0, 1'b0, 16'h0);
    #4;
    chk("t1_w0_req_valid", 32'(bus.icache_req_valid), 32'd1);
    chk("t1_w0_req_addr", {bus.icache_req_addr, 2'b00}, 32'h0);
    nxt(); #4 chk("t1_w1_de_valid", 32'(bus.fetch_de_valid), 32'd0);
    nxt(); #4 chk("t1_w2_de_valid", 32'(bus.fetch_de_valid), 32'd1);
    nxt(); bus.icache_req_ready = 1'b0;
    end_test("t1");
    chk("t1_de_count", 32'(de_wins.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < de_wins.size()) chk("t1_de_window", 32'(de_wins[i]), 32'(i + 2));

    // Predicted-taken branch at 0x8 redirects to 0x100.
    do_reset();
    bp_en = 1'b1;
    bus.icache_req_ready = 1'b1;
    push(32'h0,   f(32'h0),   1'b0, 1'b0, 16'h0);
    push(32'h4,   f(32'h4),   1'b0, 1'b0, 16'h0);
    push(32'h8,   f(32'h8),   1'b0, 1'b1, 16'hBEEF);
    push(32'h100, f(32'h100), 1'b0, 1'b0, 16'h0);
    nxt(3); #4 chk("t2_req_after_taken", {bus.icache_req_addr, 2'b00}, 32'h100);
    nxt(); bus.icache_req_ready = 1'b0;
    end_test("t2");
    bp_en = 1'b0;

    // Decode stall: queue fills to QDEPTH and requests stop.
    do_reset();
    bus.decode_stall = 1'b1;
    bus.icache_req_ready = 1'b1;
    nxt(9); #4;
    chk("t3_beats_in_stall", 32'(nbeat), 32'd4);
    chk("t3_req_valid_full", 32'(bus.icache_req_valid), 32'd0);
    chk("t3_head_valid", 32'(bus.fetch_de_valid), 32'd1);
    nxt();
    bus.decode_stall = 1'b0;
    bus.icache_req_ready = 1'b0;
    push(32'h0, f(32'h0), 1'b0, 1'b0, 16'h0);
    push(32'h4, f(32'h4), 1'b0, 1'b0, 16'h0);
    push(32'h8, f(32'h8), 1'b0, 1'b0, 16'h0);
    push(32'hC, f(32'hC), 1'b0, 1'b0, 16'h0);
    end_test("t3");

    // Flush with 3 outstanding; first stale response lands in the flush cycle.
    do_reset();
    lat = 4;
    bus.icache_req_ready = 1'b1;
    nxt(3); bus.icache_req_ready = 1'b0;
    nxt(); bus.rob_flush = 1'b1; bus.rob_flush_pc = 31'h100;
    nxt(); bus.rob_flush = 1'b0; bus.icache_req_ready = 1'b1;
    #4;
    chk("t4_de_valid_after_flush", 32'(bus.fetch_de_valid), 32'd0);
    chk("t4_req_addr_after_flush", {bus.icache_req_addr, 2'b00}, 32'h200);
    push(32'h200, f(32'h200), 1'b0, 1'b0, 16'h0);
    push(32'h204, f(32'h204), 1'b0, 1'b0, 16'h0);
    push(32'h208, f(32'h208), 1'b0, 1'b0, 16'h0);
    nxt(3); bus.icache_req_ready = 1'b0;
    end_test("t4");
    lat = 1;

    // Misaligned redirect: fault entry, HALT until the next flush.
    do_reset();
    nxt(); bus.rob_flush = 1'b1; bus.rob_flush_pc = 31'h101;
    nxt(); bus.rob_flush = 1'b0; bus.icache_req_ready = 1'b1;
    push(32'h202, 32'h0, 1'b1, 1'b0, 16'h0);
    #4 chk("t5_req_valid_misalign", 32'(bus.icache_req_valid), 32'd0);
    nxt(10); #4;
    chk("t5_beats_in_halt", 32'(nbeat), 32'd0);
    chk("t5_req_valid_halt", 32'(bus.icache_req_valid), 32'd0);
    nxt(); bus.rob_flush = 1'b1; bus.rob_flush_pc = 31'h180; bus.icache_req_ready = 1'b0;
    nxt(); bus.rob_flush = 1'b0; bus.icache_req_ready = 1'b1;
    push(32'h300, f(32'h300), 1'b0, 1'b0, 16'h0);
    nxt(); bus.icache_req_ready = 1'b0;
    end_test("t5");
    chk("t5_beats_after_flush", 32'(nbeat), 32'd1);

    // Access fault on the second response halts fetch.
    do_reset();
    err_idx = 1;
    bus.icache_req_ready = 1'b1;
    push(32'h0, f(32'h0), 1'b0, 1'b0, 16'h0);
    push(32'h4, f(32'h4), 1'b1, 1'b0, 16'h0);
    push(32'h8, f(32'h8), 1'b0, 1'b0, 16'h0);
    nxt(3); #4 chk("t6_req_valid_after_err", 32'(bus.icache_req_valid), 32'd0);
    nxt(20); #4;
    chk("t6_beats_total", 32'(nbeat), 32'd3);
    chk("t6_req_valid_halt", 32'(bus.icache_req_valid), 32'd0);
    end_test("t6");
    err_idx = -1;
    bus.icache_req_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end
endmodule
